// File: rtl/proc_pkg.sv
// ---------------------------------------------------------------------------
// proc_pkg
// Shared definitions for the small accumulator processor: instruction field
// widths, opcode constants and the fetch controller state encoding. The
// instruction memory and the fetch controller both import this package so
// the opcode map is defined in exactly one place.
//
// Instruction format (default widths): [16:12] opcode, [11:0] operand.
// Opcode map:
//   0        END   stop the program
//   1        NOP   advance pc
//   2..19    datapath operations, issued to the datapath
//   20       JPNZ  jump to operand when accumulator is non-zero
//   21       JMPZ  jump to operand when accumulator is zero
//   22..31   unassigned (trapped or treated as NOP, build dependent)
// ---------------------------------------------------------------------------
package proc_pkg;

    localparam int PC_W_DEF      = 12;
    localparam int INSTR_W_DEF   = 17;
    localparam int OPC_W_DEF     = 5;
    localparam int OPERAND_W     = 12;

    localparam int OPC_END       = 0;
    localparam int OPC_NOP       = 1;
    localparam int OPC_DP_FIRST  = 2;
    localparam int OPC_DP_LAST   = 19;
    localparam int OPC_JPNZ      = 20;
    localparam int OPC_JMPZ      = 21;
    localparam int OPC_ILL_FIRST = 22;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

endpackage

// File: rtl/instr_decode.sv
// ---------------------------------------------------------------------------
// instr_decode
// Purely combinational opcode classifier used by the fetch controller in
// the DECODE state. Exactly one of is_end / is_jump / is_dp_op / is_illegal
// is high for any opcode, except NOP, for which all of them are low.
//
// Ports:
//   opcode       in   OPC_W  opcode field of the instruction being decoded
//   is_end       out  1      END instruction
//   is_jump      out  1      JPNZ or JMPZ
//   jump_on_zero out  1      the jump is taken when z_flag=1 (JMPZ)
//   is_dp_op     out  1      datapath operation (2..19)
//   is_illegal   out  1      unassigned opcode (22 and above)
// ---------------------------------------------------------------------------
module instr_decode
    import proc_pkg::*;
#(
    parameter int OPC_W = OPC_W_DEF
) (
    input  logic [OPC_W-1:0] opcode,
    output logic             is_end,
    output logic             is_jump,
    output logic             jump_on_zero,
    output logic             is_dp_op,
    output logic             is_illegal
);

    int opc_val;

    // Compare as an integer so the range checks do not depend on OPC_W.
    always_comb begin
        opc_val      = int'(opcode);
        is_end       = (opc_val == OPC_END);
        is_jump      = (opc_val == OPC_JPNZ) || (opc_val == OPC_JMPZ);
        jump_on_zero = (opc_val == OPC_JMPZ);
        is_dp_op     = (opc_val >= OPC_DP_FIRST) && (opc_val <= OPC_DP_LAST);
        is_illegal   = (opc_val >= OPC_ILL_FIRST);
    end

endmodule

// File: rtl/fetch_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_ctrl
// Instruction fetch / decode / issue controller. Fetches one instruction per
// FETCH cycle from a synchronous instruction memory, classifies it in DECODE,
// resolves NOP and conditional jumps locally and hands datapath operations
// to the datapath in EXEC with a valid/done handshake.
//
// Optional feature: define FETCH_CTRL_ILLEGAL_TRAP_EN to halt on opcodes
// 22..31 and report them on illegal_op. Without it those opcodes behave as
// NOP and the illegal_op port does not exist.
//
// Ports:
//   clk          in   1        rising-edge clock
//   rst          in   1        synchronous active-high reset
//   start        in   1        launch program at address 0 (IDLE / HALT only)
//   mem_read_en  out  1        instruction memory read, high only in FETCH
//   mem_addr     out  PC_W     instruction memory address (= pc)
//   instr_in     in   INSTR_W  instruction data, valid the cycle after read
//   z_flag       in   1        accumulator-zero flag, used by JPNZ/JMPZ
//   op_valid     out  1        datapath operation issued (EXEC)
//   op_code      out  OPC_W    opcode of the issued operation
//   op_operand   out  12       operand of the issued operation
//   op_done      in   1        datapath finished the issued operation
//   pc           out  PC_W     program counter
//   busy         out  1        controller is running (not IDLE / HALT)
//   halted       out  1        controller is in HALT
//   illegal_op   out  1        trapped opcode seen (trap build only)
// ---------------------------------------------------------------------------
module fetch_ctrl
    import proc_pkg::*;
#(
    parameter int PC_W    = PC_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF,
    parameter int OPC_W   = OPC_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 mem_read_en,
    output logic [PC_W-1:0]      mem_addr,
    input  logic [INSTR_W-1:0]   instr_in,
    input  logic                 z_flag,
    output logic                 op_valid,
    output logic [OPC_W-1:0]     op_code,
    output logic [OPERAND_W-1:0] op_operand,
    input  logic                 op_done,
    output logic [PC_W-1:0]      pc,
    output logic                 busy,
    output logic                 halted
`ifdef FETCH_CTRL_ILLEGAL_TRAP_EN
    ,
    output logic                 illegal_op
`endif
);

    state_t             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] ir_q, ir_d;

    logic [PC_W-1:0]    pc_inc;
    logic [PC_W-1:0]    jump_target;
    logic               jump_taken;

    logic               dec_is_end;
    logic               dec_is_jump;
    logic               dec_jump_on_zero;
    logic               dec_is_dp_op;
    logic               dec_is_illegal;

`ifdef FETCH_CTRL_ILLEGAL_TRAP_EN
    logic               illegal_q, illegal_d;
`endif

    // Classification works on the incoming memory word, not the IR, so the
    // branch decision is made in the same cycle the word is latched.
    instr_decode #(
        .OPC_W (OPC_W)
    ) u_instr_decode (
        .opcode       (instr_in[INSTR_W-1 -: OPC_W]),
        .is_end       (dec_is_end),
        .is_jump      (dec_is_jump),
        .jump_on_zero (dec_jump_on_zero),
        .is_dp_op     (dec_is_dp_op),
        .is_illegal   (dec_is_illegal)
    );

    // Increment wraps naturally at PC_W bits; the size cast truncates (or
    // zero-extends) the 12-bit operand to a PC_W-bit jump target.
    assign pc_inc      = pc_q + PC_W'(1);
    assign jump_target = PC_W'(instr_in[OPERAND_W-1:0]);
    assign jump_taken  = dec_jump_on_zero ? z_flag : ~z_flag;

    // Next-state logic: start is honoured only when stopped, z_flag only in
    // DECODE and op_done only in EXEC.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
`ifdef FETCH_CTRL_ILLEGAL_TRAP_EN
        illegal_d = illegal_q;
`endif
        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (start) begin
                    state_d   = ST_FETCH;
                    pc_d      = '0;
`ifdef FETCH_CTRL_ILLEGAL_TRAP_EN
                    illegal_d = 1'b0;
`endif
                end
            end
            ST_FETCH: begin
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                ir_d = instr_in;
                if (dec_is_end) begin
                    state_d = ST_HALT;
                end else if (dec_is_dp_op) begin
                    state_d = ST_EXEC;
                end else if (dec_is_jump) begin
                    state_d = ST_FETCH;
                    pc_d    = jump_taken ? jump_target : pc_inc;
`ifdef FETCH_CTRL_ILLEGAL_TRAP_EN
                end else if (dec_is_illegal) begin
                    state_d   = ST_HALT;
                    illegal_d = 1'b1;
`else
                end else if (dec_is_illegal) begin
                    state_d = ST_FETCH;
                    pc_d    = pc_inc;
`endif
                end else begin
                    state_d = ST_FETCH;
                    pc_d    = pc_inc;
                end
            end
            ST_EXEC: begin
                if (op_done) begin
                    state_d = ST_FETCH;
                    pc_d    = pc_inc;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, pc and instruction register; reset takes priority over start
    // and op_done arriving on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

`ifdef FETCH_CTRL_ILLEGAL_TRAP_EN
    // Sticky trap flag, cleared only by reset or a new start.
    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
        end
    end

    assign illegal_op = illegal_q;
`endif

    // Outputs are decoded from registered state, so every one of them is 0
    // in the cycle after reset. The issued operation comes straight from the
    // IR, which holds still for the whole of EXEC.
    assign mem_read_en = (state_q == ST_FETCH);
    assign mem_addr    = pc_q;
    assign op_valid    = (state_q == ST_EXEC);
    assign op_code     = ir_q[INSTR_W-1 -: OPC_W];
    assign op_operand  = ir_q[OPERAND_W-1:0];
    assign pc          = pc_q;
    assign busy        = (state_q != ST_IDLE) && (state_q != ST_HALT);
    assign halted      = (state_q == ST_HALT);

endmodule
